// File: rtl/mul_div_if.sv
// Request/response bundle between the execute stage and the HI/LO multiply/divide unit.
interface mul_div_if #(parameter int BitWidth = 32);
  logic                start;
  logic [2:0]          op;
  logic [BitWidth-1:0] a;
  logic [BitWidth-1:0] b;
  logic                abort;
  logic                busy;
  logic                done;
  logic [BitWidth-1:0] hi;
  logic [BitWidth-1:0] lo;
  logic                div_by_zero;

  modport master (output start, op, a, b, abort,
                  input  busy, done, hi, lo, div_by_zero);
  modport slave  (input  start, op, a, b, abort,
                  output busy, done, hi, lo, div_by_zero);
endinterface

// File: rtl/mul_div_unit.sv
// Iterative signed/unsigned MULT/DIV (one radix-2 step per cycle) owning the HI/LO pair.
module mul_div_unit #(
  parameter int BitWidth = 32
) (
  input  logic clk,
  input  logic rst_n,
  mul_div_if.slave bus
);
  localparam int W  = BitWidth;
  localparam int CW = $clog2(W);
  localparam logic [2:0] OP_MULT = 3'd0, OP_MULTU = 3'd1, OP_DIV = 3'd2,
                         OP_DIVU = 3'd3, OP_MTHI = 3'd4, OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  state_t state, nxt;

  logic [CW-1:0]  cnt;
  logic [2*W:0]   acc;      // MUL: {upper, multiplier}; DIV: {remainder, quotient}
  logic [W-1:0]   opb;      // multiplicand or divisor magnitude
  logic           neg_res, neg_rem, is_div, dz_pend;
  logic           done_r, dz_r;
  logic [W-1:0]   hi_r, lo_r;

  logic           last, is_sgn, a_neg, b_neg;
  logic [W-1:0]   mag_a, mag_b;
  logic [W:0]     sum;
  logic [W:0]     rsh;
  logic [W+1:0]   diff;
  logic [2*W:0]   mul_nxt, div_nxt;
  logic [2*W-1:0] prod;
  logic [W-1:0]   quo, rem;

  assign last   = (cnt == CW'(W-1));
  assign is_sgn = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign a_neg  = is_sgn & bus.a[W-1];
  assign b_neg  = is_sgn & bus.b[W-1];
  assign mag_a  = a_neg ? -bus.a : bus.a;
  assign mag_b  = b_neg ? -bus.b : bus.b;

  // shift-add: add multiplicand into upper half when LSB set, then shift right
  assign sum     = {1'b0, acc[2*W-1:W]} + {1'b0, opb};
  assign mul_nxt = acc[0] ? {1'b0, sum, acc[W-1:1]} : {1'b0, acc[2*W:1]};

  // restoring divide: keep the trial subtraction only when it does not borrow
  assign rsh     = {acc[2*W-1:W], acc[W-1]};
  assign diff    = {1'b0, rsh} - {2'b0, opb};
  assign div_nxt = diff[W+1] ? {rsh, acc[W-2:0], 1'b0}
                             : {diff[W:0], acc[W-2:0], 1'b1};

  assign prod = neg_res ? -acc[2*W-1:0] : acc[2*W-1:0];
  assign quo  = neg_res ? -acc[W-1:0]   : acc[W-1:0];
  assign rem  = neg_rem ? -acc[2*W-1:W] : acc[2*W-1:W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (bus.abort) nxt = IDLE;
    else begin
      case (state)
        IDLE: if (bus.start) begin
          if (bus.op == OP_MULT || bus.op == OP_MULTU)     nxt = MUL;
          else if (bus.op == OP_DIV || bus.op == OP_DIVU)  nxt = DIV;
        end
        MUL, DIV: if (last) nxt = FIX;
        FIX:      nxt = IDLE;
        default:  nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.busy        = (state != IDLE);
    bus.done        = done_r;
    bus.hi          = hi_r;
    bus.lo          = lo_r;
    bus.div_by_zero = dz_r;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0; acc <= '0; opb <= '0;
      neg_res <= 1'b0; neg_rem <= 1'b0; is_div <= 1'b0; dz_pend <= 1'b0;
      done_r <= 1'b0; dz_r <= 1'b0; hi_r <= '0; lo_r <= '0;
    end else begin
      done_r <= 1'b0;
      if (!bus.abort) begin
        case (state)
          IDLE: if (bus.start) begin
            cnt     <= '0;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            dz_pend <= (bus.b == '0);
            case (bus.op)
              OP_MULT, OP_MULTU: begin
                acc <= {{(W+1){1'b0}}, mag_b}; opb <= mag_a; is_div <= 1'b0; dz_r <= 1'b0;
              end
              OP_DIV, OP_DIVU: begin
                acc <= {{(W+1){1'b0}}, mag_a}; opb <= mag_b; is_div <= 1'b1; dz_r <= 1'b0;
              end
              OP_MTHI: begin hi_r <= bus.a; done_r <= 1'b1; dz_r <= 1'b0; end
              OP_MTLO: begin lo_r <= bus.a; done_r <= 1'b1; dz_r <= 1'b0; end
              default: ;
            endcase
          end
          MUL: begin acc <= mul_nxt; cnt <= cnt + CW'(1); end
          DIV: begin acc <= div_nxt; cnt <= cnt + CW'(1); end
          FIX: begin
            done_r <= 1'b1;
            dz_r   <= is_div & dz_pend;
            if (is_div) begin
              // divide-by-zero: all-ones quotient, remainder fix-up restores original a
              lo_r <= dz_pend ? '1 : quo;
              hi_r <= rem;
            end else begin
              {hi_r, lo_r} <= prod;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule
